// File: rtl/lt_cmp_arbiter_pkg.sv
// Shared types and helpers for the shared-comparator arbiter: requester tag width
// and the round-robin pick used by the arbiter.
package lt_cmp_pkg;

    localparam int unsigned MAX_REQ         = 16;
    localparam int unsigned IDX_W           = $clog2(MAX_REQ);
    localparam int unsigned DEFAULT_NUM_REQ = 4;

    typedef enum int {
        IMPL_BEHAV = 0,
        IMPL_RIPPLE = 1
    } impl_e;

    function automatic int unsigned calc_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_ID_W = calc_id_w(DEFAULT_NUM_REQ);

    // Unused upper request bits must be zero: a mod-16 wrap then visits the live
    // requesters in the same order as a mod-NUM_REQ wrap would.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr);
        logic [MAX_REQ-1:0] grant;
        logic [IDX_W-1:0]   idx;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/lt_cmp_arbiter_if.sv
// Request/response bundle between compute clients and the shared comparator.
interface lt_cmp_arbiter_if
    import lt_cmp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32
);
    localparam int unsigned ID_W = calc_id_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_lt;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_lt
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_lt
    );
endinterface

// File: rtl/lt_cmp_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the pointer moves past a winner
// only when the grant is actually taken.
module rr_arbiter
    import lt_cmp_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] grant_pad;
    logic [IDX_W-1:0]   ptr_pad;

    always_comb begin
        req_pad                = '0;
        req_pad[NUM_REQ-1:0]   = req_i;
        ptr_pad                = '0;
        ptr_pad[ID_W-1:0]      = ptr_q;
        grant_pad              = rr_pick(req_pad, ptr_pad);
        grant_o                = grant_pad[NUM_REQ-1:0];
        idx_o                  = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (grant_pad[i]) idx_o = ID_W'(i);
        end
        ptr_d = ptr_q;
        if (adv_i && |grant_o) begin
            ptr_d = (idx_o == ID_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/lt_uint_nbit.sv
// Unsigned WIDTH-bit less-than comparator with selectable implementation.
module lt_uint_nbit
    import lt_cmp_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int          IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             lt_o
);

    generate
        if (IMPL_TYPE == IMPL_RIPPLE) begin : g_ripple
            // The most significant differing bit is visited last, so it decides.
            always_comb begin
                lt_o = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (a_i[i] != b_i[i]) lt_o = b_i[i];
                end
            end
        end else begin : g_behav
            assign lt_o = (a_i < b_i);
        end
    endgenerate

endmodule

// File: rtl/lt_cmp_arbiter.sv
// Shares one lt_uint_nbit among NUM_REQ requesters: round-robin accept into an
// operand register, compare, then a result register with backpressure.
module lt_cmp_arbiter
    import lt_cmp_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int          IMPL_TYPE = 0
) (
    input logic              clk,
    input logic              rst_n,
    lt_cmp_arbiter_if.slave  bus
);

    localparam int unsigned ID_W = calc_id_w(NUM_REQ);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             s2_valid_q, s2_valid_d;
    logic             lt_q, lt_d;
    logic [ID_W-1:0]  s2_id_q, s2_id_d;

    logic               s2_free, s1_adv, accept_ok, fire, cmp_lt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   a_sel, b_sel;

    assign s2_free   = !s2_valid_q || bus.rsp_ready;
    assign s1_adv    = s1_valid_q && s2_free;
    assign accept_ok = !s1_valid_q || s1_adv;

    // Ready is forced low throughout reset even though the empty pipe could accept.
    assign bus.req_ready = rst_n ? (grant & {NUM_REQ{accept_ok}}) : '0;
    assign fire          = |bus.req_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (bus.req_valid),
        .adv_i   (accept_ok),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = bus.req_a[i*WIDTH +: WIDTH];
                b_sel = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    lt_uint_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_cmp (
        .a_i  (a_q),
        .b_i  (b_q),
        .lt_o (cmp_lt)
    );

    always_comb begin
        s2_valid_d = s2_valid_q;
        lt_d       = lt_q;
        s2_id_d    = s2_id_q;
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        s1_id_d    = s1_id_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            lt_d       = cmp_lt;
            s2_id_d    = s1_id_q;
        end else if (bus.rsp_ready) begin
            s2_valid_d = 1'b0;
        end
        if (fire) begin
            s1_valid_d = 1'b1;
            a_d        = a_sel;
            b_d        = b_sel;
            s1_id_d    = grant_idx;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            lt_q       <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            lt_q       <= lt_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_id    = s2_id_q;
    assign bus.rsp_lt    = lt_q;

    // A pending requester must not change its operands until it is accepted.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold_chk
            assert property (@(posedge clk) disable iff (!rst_n)
                (bus.req_valid[g] && !bus.req_ready[g]) |=>
                (!bus.req_valid[g] ||
                 ($stable(bus.req_a[g*WIDTH +: WIDTH]) && $stable(bus.req_b[g*WIDTH +: WIDTH]))));
        end
    endgenerate

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));

endmodule
